// File: rtl/i2c_master_arb_pkg.sv
// Shared types for the I2C master arbiter: engine opcodes, arbiter state codes
// and a small one-hot to index helper.
package i2c_master_arb_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WR    = 2'd1,
        OP_RD    = 2'd2,
        OP_STOP  = 2'd3
    } i2c_op_t;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 3'd0;
    localparam arb_state_t ARB_OWN   = 3'd1;
    localparam arb_state_t ARB_WAIT  = 3'd2;
    localparam arb_state_t ARB_FSTOP = 3'd3;
    localparam arb_state_t ARB_FWAIT = 3'd4;

    // Index of the highest set bit; callers only pass one-hot vectors.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_master_arb_if.sv
// Command/response link between the arbiter and the byte-level I2C engine.
interface i2c_master_arb_if;
    import i2c_master_arb_pkg::*;

    logic       m_cmd_valid;
    logic       m_cmd_ready;
    i2c_op_t    m_cmd_op;
    logic [7:0] m_cmd_data;
    logic       m_cmd_nack;
    logic       m_rsp_valid;
    logic [7:0] m_rsp_data;
    logic       m_rsp_nack;
    logic       m_arb_lost;

    modport master (
        output m_cmd_valid, m_cmd_op, m_cmd_data, m_cmd_nack,
        input  m_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_nack, m_arb_lost
    );

    modport slave (
        input  m_cmd_valid, m_cmd_op, m_cmd_data, m_cmd_nack,
        output m_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_nack, m_arb_lost
    );

endinterface

// File: rtl/i2c_master_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// searching upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        int idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arb.sv
// Shares one byte-level I2C engine among NREQ clients, locking the grant from
// START until STOP completes and forcing a STOP when an owner goes silent.
module i2c_master_arb
    import i2c_master_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   cmd_valid,
    output logic [NREQ-1:0]   cmd_ready,
    input  logic [2*NREQ-1:0] cmd_op,
    input  logic [8*NREQ-1:0] cmd_data,
    input  logic [NREQ-1:0]   cmd_nack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic [NREQ-1:0]   grant,
    output logic              timeout,
    i2c_master_arb_if.master  eng
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_t      state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    i2c_op_t         op_reg, op_next;
    logic [CW-1:0]   tcnt_reg, tcnt_next;
    logic            timeout_reg, timeout_next;

    logic [1:0]      op_arr   [NREQ];
    logic [7:0]      data_arr [NREQ];
    logic [NREQ-1:0] start_req;
    logic [NREQ-1:0] win_gnt;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   ptr_after;

    logic            own_valid;
    i2c_op_t         own_op;
    logic [7:0]      own_data;
    logic            own_nack;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_arr[gi]    = cmd_op[2*gi +: 2];
            assign data_arr[gi]  = cmd_data[8*gi +: 8];
            assign start_req[gi] = cmd_valid[gi] && (cmd_op[2*gi +: 2] == OP_START);
            // Non-owners never see ready; their commands simply wait for a grant.
            assign cmd_ready[gi] = (state_reg == ARB_OWN) && (owner_reg == IW'(gi))
                                   && eng.m_cmd_ready;
            assign rsp_valid[gi] = (state_reg == ARB_WAIT) && (owner_reg == IW'(gi))
                                   && eng.m_rsp_valid;
        end
    endgenerate

    rr_arbiter #(
        .N  (NREQ),
        .PW (IW)
    ) u_rr (
        .req (start_req),
        .ptr (ptr_reg),
        .gnt (win_gnt)
    );

    assign win_idx   = IW'(oh_to_idx(8'(win_gnt)));
    assign ptr_after = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

    assign own_valid = cmd_valid[owner_reg];
    assign own_op    = i2c_op_t'(op_arr[owner_reg]);
    assign own_data  = data_arr[owner_reg];
    assign own_nack  = cmd_nack[owner_reg];

    always_comb begin
        eng.m_cmd_valid = 1'b0;
        eng.m_cmd_op    = OP_START;
        eng.m_cmd_data  = 8'h00;
        eng.m_cmd_nack  = 1'b0;
        case (state_reg)
            ARB_OWN: begin
                eng.m_cmd_valid = own_valid;
                eng.m_cmd_op    = own_op;
                eng.m_cmd_data  = own_data;
                eng.m_cmd_nack  = own_nack;
            end
            ARB_FSTOP: begin
                eng.m_cmd_valid = 1'b1;
                eng.m_cmd_op    = OP_STOP;
            end
            default: ;
        endcase
    end

    // Response fields are held at zero except while the owner's pulse is live.
    assign rsp_data = (state_reg == ARB_WAIT && eng.m_rsp_valid) ? eng.m_rsp_data : 8'h00;
    assign rsp_err  = (state_reg == ARB_WAIT && eng.m_rsp_valid)
                      && (eng.m_rsp_nack || eng.m_arb_lost);
    assign grant    = grant_reg;
    assign timeout  = timeout_reg;

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        grant_next   = grant_reg;
        ptr_next     = ptr_reg;
        op_next      = op_reg;
        tcnt_next    = tcnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (|start_req) begin
                    state_next = ARB_OWN;
                    owner_next = win_idx;
                    grant_next = win_gnt;
                    tcnt_next  = '0;
                end
            end
            ARB_OWN: begin
                if (own_valid && eng.m_cmd_ready) begin
                    op_next    = own_op;
                    tcnt_next  = '0;
                    state_next = ARB_WAIT;
                end else if (!own_valid && TIMEOUT_CYC != 0) begin
                    // A command presented on the limit cycle takes the branch above.
                    if (tcnt_reg == CW'(TIMEOUT_CYC)) begin
                        state_next   = ARB_FSTOP;
                        timeout_next = 1'b1;
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            ARB_WAIT: begin
                if (eng.m_rsp_valid) begin
                    if (eng.m_arb_lost || op_reg == OP_STOP) begin
                        state_next = ARB_IDLE;
                        grant_next = '0;
                        owner_next = '0;
                        ptr_next   = ptr_after;
                    end else begin
                        state_next = ARB_OWN;
                        tcnt_next  = '0;
                    end
                end
            end
            ARB_FSTOP: begin
                if (eng.m_cmd_ready) begin
                    state_next = ARB_FWAIT;
                end
            end
            ARB_FWAIT: begin
                if (eng.m_rsp_valid) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    owner_next = '0;
                    ptr_next   = ptr_after;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= ARB_IDLE;
            owner_reg   <= '0;
            grant_reg   <= '0;
            ptr_reg     <= '0;
            op_reg      <= OP_START;
            tcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            grant_reg   <= grant_next;
            ptr_reg     <= ptr_next;
            op_reg      <= op_next;
            tcnt_reg    <= tcnt_next;
            timeout_reg <= timeout_next;
        end
    end

endmodule
